// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter among four requesters
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req[3:0]        per-requester request level, sampled only in IDLE
//   i_req_data[31:0]  byte of requester i at [8i+7:8i]
//   o_gnt[3:0]        one-hot pulse in the first ARM cycle
//   o_done[3:0]       one-hot pulse when the owner's frame has finished
//   o_err             pulse when the transmitter never started the frame
//   o_owner[1:0]      current or last granted requester
//   o_busy            high whenever the scheduler is not IDLE
//   o_tx_data[7:0]    byte presented to the transmitter
//   o_tx_int          start strobe; its falling edge starts a frame
//   i_tx_busy         transmitter busy flag
// PULSE_CYC legal 3..255, START_TIMEOUT legal 1..255.
module uart_tx_sched #(
    parameter int PULSE_CYC     = 4,
    parameter int START_TIMEOUT = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_req,
    input  logic [31:0] i_req_data,
    output logic [3:0]  o_gnt,
    output logic [3:0]  o_done,
    output logic        o_err,
    output logic [1:0]  o_owner,
    output logic        o_busy,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_int,
    input  logic        i_tx_busy
);
    typedef enum logic [2:0] {IDLE, ARM, FIRE, SEND, FIN} state_t;
    state_t      r_state, w_next;
    logic [1:0]  r_last, r_owner, w_win, w_idx;
    logic [7:0]  r_cnt, r_tcnt, r_tx_data;
    logic        r_err, w_found, w_grant, w_timeout;

    assign o_owner   = r_owner;
    assign o_tx_data = r_tx_data;

    // Search starts just after the last winner and wraps, so a held request cannot starve others.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_idx   = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_timeout = 1'b0;
        o_tx_int  = 1'b0;
        o_gnt     = 4'b0000;
        o_done    = 4'b0000;
        o_err     = 1'b0;
        o_busy    = r_state != IDLE;
        case (r_state)
            IDLE: begin
                w_grant = w_found && !i_tx_busy;
                w_next  = w_grant ? ARM : IDLE;
            end
            ARM: begin
                o_tx_int = 1'b1;
                o_gnt    = (r_cnt == 8'd0) ? 4'b0001 << r_owner : 4'b0000;
                w_next   = (r_cnt == 8'(PULSE_CYC - 1)) ? FIRE : ARM;
            end
            FIRE: begin
                // A frame that starts on the last allowed cycle still wins over the timeout.
                w_timeout = !i_tx_busy && (r_tcnt == 8'(START_TIMEOUT - 1));
                w_next    = i_tx_busy ? SEND : (w_timeout ? FIN : FIRE);
            end
            SEND: w_next = i_tx_busy ? SEND : FIN;
            FIN: begin
                o_done = r_err ? 4'b0000 : 4'b0001 << r_owner;
                o_err  = r_err;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last    <= 2'd3;
            r_owner   <= 2'd0;
            r_tx_data <= 8'h00;
            r_cnt     <= 8'd0;
            r_tcnt    <= 8'd0;
            r_err     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_last    <= w_win;
                r_owner   <= w_win;
                r_tx_data <= i_req_data[{w_win, 3'b000} +: 8];
            end
            r_cnt  <= (r_state == ARM)  ? r_cnt + 8'd1  : 8'd0;
            r_tcnt <= (r_state == FIRE) ? r_tcnt + 8'd1 : 8'd0;
            if (r_state == FIRE) r_err <= w_timeout;
        end
    end
endmodule
